// File: rtl/key_search_if.sv
// Request / register-file read / response bundle of the key search engine.
interface key_search_if #(
  parameter int KEY_WIDTH   = 32,
  parameter int INDEX_WIDTH = 8
);
  logic                     req_valid;
  logic                     req_ready;
  logic [KEY_WIDTH-1:0]     req_key;
  logic [INDEX_WIDTH:0]     num_keys;
  logic [2*INDEX_WIDTH-1:0] r_addr;
  logic [1:0]               r_en;
  logic [2*KEY_WIDTH-1:0]   key_out_read;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic                     rsp_hit;
  logic [INDEX_WIDTH-1:0]   rsp_index;

  // Engine side: accepts lookups, drives register-file reads, produces responses.
  modport slave (
    input  req_valid, req_key, num_keys, key_out_read, rsp_ready,
    output req_ready, r_addr, r_en, rsp_valid, rsp_hit, rsp_index
  );

  // Requester / register-file side.
  modport master (
    output req_valid, req_key, num_keys, key_out_read, rsp_ready,
    input  req_ready, r_addr, r_en, rsp_valid, rsp_hit, rsp_index
  );
endinterface

// File: rtl/key_search_engine.sv
// Linear key search over a dual-port key register file, two entries per cycle.
//
// state | meaning
// IDLE  | waiting for a lookup request (req_ready=1)
// SCAN  | issuing read pairs and comparing returned keys
// RESP  | holding the result until rsp_ready
module key_search_engine #(
  parameter int KEY_WIDTH   = 32,
  parameter int INDEX_WIDTH = 8
) (
  input logic         clk,
  input logic         reset,
  key_search_if.slave bus
);
  localparam int CW = INDEX_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH = CW'(2 ** INDEX_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESP} state_t;

  state_t                 r_state, w_next;
  logic [KEY_WIDTH-1:0]   r_key;
  logic [CW-1:0]          r_count;
  logic [INDEX_WIDTH-1:0] r_pair;
  logic                   r_issuing;
  logic [1:0]             r_vld;
  logic [INDEX_WIDTH-1:0] r_base;
  logic                   r_last_d;
  logic                   r_hit;
  logic [INDEX_WIDTH-1:0] r_index;

  logic [CW-1:0]          w_count_in, w_lo, w_hi;
  logic                   w_accept, w_last, w_m0, w_m1, w_match, w_issue;

  assign w_count_in = (bus.num_keys > DEPTH) ? DEPTH : bus.num_keys;
  assign w_accept   = bus.req_valid && (r_state == S_IDLE);
  assign w_lo       = {r_pair, 1'b0};
  assign w_hi       = w_lo + CW'(1);
  assign w_last     = (w_lo + CW'(2)) >= r_count;
  // Only lanes whose read was actually issued last cycle are compared; the
  // register file holds stale data on idle lanes.
  assign w_m0       = r_vld[0] && (bus.key_out_read[0 +: KEY_WIDTH] == r_key);
  assign w_m1       = r_vld[1] && (bus.key_out_read[KEY_WIDTH +: KEY_WIDTH] == r_key);
  assign w_match    = w_m0 || w_m1;
  // A hit suppresses the read that would otherwise go out in the same cycle.
  assign w_issue    = (r_state == S_SCAN) && r_issuing && !w_match;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (w_count_in == '0) ? S_RESP : S_SCAN;
      S_SCAN: if (w_match || r_last_d) w_next = S_RESP;
      S_RESP: if (bus.rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state and scan position.
  always_comb begin
    bus.req_ready = (r_state == S_IDLE);
    bus.rsp_valid = (r_state == S_RESP);
    bus.rsp_hit   = r_hit;
    bus.rsp_index = r_index;
    bus.r_en[0]   = w_issue && (w_lo < r_count);
    bus.r_en[1]   = w_issue && (w_hi < r_count);
    bus.r_addr    = '0;
    if (r_state == S_SCAN)
      bus.r_addr = {w_hi[INDEX_WIDTH-1:0], w_lo[INDEX_WIDTH-1:0]};
  end

  // Request capture, pair counter and read-side tracking aligned to read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key     <= '0;
      r_count   <= '0;
      r_pair    <= '0;
      r_issuing <= 1'b0;
      r_vld     <= 2'b00;
      r_base    <= '0;
      r_last_d  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_key     <= bus.req_key;
        r_count   <= w_count_in;
        r_pair    <= '0;
        r_issuing <= (w_count_in != '0);
      end else if (w_issue) begin
        if (w_last) r_issuing <= 1'b0;
        else        r_pair    <= r_pair + 1'b1;
      end
      r_vld    <= bus.r_en;
      r_base   <= w_lo[INDEX_WIDTH-1:0];
      r_last_d <= w_issue && w_last;
    end
  end

  // Result registers, held while the response waits for rsp_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hit   <= 1'b0;
      r_index <= '0;
    end else if (w_accept && (w_count_in == '0)) begin
      r_hit   <= 1'b0;
      r_index <= '0;
    end else if (r_state == S_SCAN) begin
      if (w_m0) begin
        r_hit   <= 1'b1;
        r_index <= r_base;
      end else if (w_m1) begin
        r_hit   <= 1'b1;
        r_index <= r_base | INDEX_WIDTH'(1);
      end else if (r_last_d) begin
        r_hit   <= 1'b0;
        r_index <= '0;
      end
    end
  end
endmodule

// File: tb/tb_key_search_engine.sv
// Self-checking bench for key_search_engine with a dual-port register file model.
module tb_key_search_engine;
  localparam int KW = 32;
  localparam int IW = 8;
  localparam int DEPTH = 256;

  typedef struct {
    logic          hit;
    logic [IW-1:0] idx;
    int            lat;
    int            en_cycles;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  key_search_if #(.KEY_WIDTH(KW), .INDEX_WIDTH(IW)) bus ();
  key_search_engine #(.KEY_WIDTH(KW), .INDEX_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  logic [KW-1:0] mem [DEPTH];

  // Register file read ports: one-cycle latency, output held when not enabled.
  always @(posedge clk) begin
    if (bus.r_en[0]) bus.key_out_read[0 +: KW]  <= mem[bus.r_addr[0 +: IW]];
    if (bus.r_en[1]) bus.key_out_read[KW +: KW] <= mem[bus.r_addr[IW +: IW]];
  end

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int act_lat;
  logic act_hit;
  logic [IW-1:0] act_idx;
  int en_cycles;
  int last_en_cyc;
  logic [1:0] en_log [0:511];
  logic [2*IW-1:0] addr_log [0:511];

  function automatic exp_t model(input logic [KW-1:0] key, input int num);
    exp_t e;
    int cnt;
    cnt = (num > DEPTH) ? DEPTH : num;
    e.hit = 1'b0; e.idx = '0;
    e.lat = (cnt == 0) ? 1 : (cnt + 1) / 2 + 2;
    e.en_cycles = (cnt + 1) / 2;
    for (int i = 0; i < cnt; i++) begin
      if (mem[i] == key) begin
        e.hit = 1'b1; e.idx = IW'(i);
        e.lat = i / 2 + 3; e.en_cycles = i / 2 + 1;
        return e;
      end
    end
    return e;
  endfunction

  // Issue one request and observe until rsp_valid (ends at the negedge where it is seen).
  task automatic do_lookup(input logic [KW-1:0] key, input int num);
    int cyc;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_key = key; bus.num_keys = (IW+1)'(num);
    sb.push_back(model(key, num));
    @(posedge clk);
    cyc = 1; en_cycles = 0; last_en_cyc = 0; act_lat = -1;
    act_hit = 1'bx; act_idx = 'x;
    for (int i = 0; i < 512; i++) begin en_log[i] = 2'b00; addr_log[i] = '0; end
    while (cyc <= 400) begin
      @(negedge clk);
      if (cyc == 1) bus.req_valid = 1'b0;
      en_log[cyc] = bus.r_en;
      addr_log[cyc] = bus.r_addr;
      if (bus.r_en != 2'b00) begin en_cycles++; last_en_cyc = cyc; end
      if (bus.rsp_valid) begin
        act_lat = cyc; act_hit = bus.rsp_hit; act_idx = bus.rsp_index;
        break;
      end
      cyc++;
    end
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic fill_seq(input logic [KW-1:0] base);
    for (int i = 0; i < DEPTH; i++) mem[i] = base + KW'(i);
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
    tests++; if ({bus.r_en, bus.r_addr} !== '0) begin fails++; $display("FAIL reset_reads: got en=%b addr=%h expected 0", bus.r_en, bus.r_addr); end
    tests++; if ({bus.rsp_valid, bus.rsp_hit, bus.rsp_index} !== '0) begin fails++; $display("FAIL reset_rsp: got v=%b h=%b i=%0d expected 0", bus.rsp_valid, bus.rsp_hit, bus.rsp_index); end
    reset = 1'b1;
  endtask

  task automatic test_hit_first();
    exp_t e;
    for (int i = 0; i < 8; i++) mem[i] = 32'd100 + i;
    do_lookup(32'd100, 8);
    e = sb.pop_front();
    tests++; if (act_lat !== e.lat) begin fails++; $display("FAIL hit0_latency: got %0d expected %0d", act_lat, e.lat); end
    tests++; if ({act_hit, act_idx} !== {e.hit, e.idx}) begin fails++; $display("FAIL hit0_result: got hit=%b idx=%0d expected hit=%b idx=%0d", act_hit, act_idx, e.hit, e.idx); end
    tests++; if (en_cycles !== 1 || en_log[1] !== 2'b11) begin fails++; $display("FAIL hit0_reads: got %0d cycles first=%b expected 1 cycles 11", en_cycles, en_log[1]); end
    consume();
  endtask

  task automatic test_hit_mid();
    exp_t e;
    do_lookup(32'd105, 8);
    e = sb.pop_front();
    tests++; if (act_lat !== e.lat) begin fails++; $display("FAIL hit5_latency: got %0d expected %0d", act_lat, e.lat); end
    tests++; if ({act_hit, act_idx} !== {e.hit, e.idx}) begin fails++; $display("FAIL hit5_result: got hit=%b idx=%0d expected hit=%b idx=%0d", act_hit, act_idx, e.hit, e.idx); end
    tests++; if (en_cycles !== e.en_cycles || last_en_cyc !== 3) begin fails++; $display("FAIL hit5_reads: got %0d cycles last=%0d expected %0d cycles last=3", en_cycles, last_en_cyc, e.en_cycles); end
    tests++; if (addr_log[3] !== {8'd5, 8'd4} || addr_log[2] !== {8'd3, 8'd2}) begin fails++; $display("FAIL hit5_addr: got c2=%h c3=%h expected 0302 0504", addr_log[2], addr_log[3]); end
    consume();
  endtask

  task automatic test_duplicate();
    exp_t e;
    mem[6] = 32'hDEADBEEF; mem[7] = 32'hDEADBEEF;
    do_lookup(32'hDEADBEEF, 8);
    e = sb.pop_front();
    tests++; if ({act_hit, act_idx} !== {1'b1, 8'd6} || {e.hit, e.idx} !== {1'b1, 8'd6}) begin fails++; $display("FAIL dup_priority: got hit=%b idx=%0d expected hit=1 idx=6", act_hit, act_idx); end
    tests++; if (act_lat !== e.lat) begin fails++; $display("FAIL dup_latency: got %0d expected %0d", act_lat, e.lat); end
    consume();
  endtask

  task automatic test_miss();
    exp_t e;
    do_lookup(32'd999, 7);
    e = sb.pop_front();
    tests++; if (act_lat !== e.lat) begin fails++; $display("FAIL miss7_latency: got %0d expected %0d", act_lat, e.lat); end
    tests++; if ({act_hit, act_idx} !== 9'd0) begin fails++; $display("FAIL miss7_result: got hit=%b idx=%0d expected 0 0", act_hit, act_idx); end
    tests++; if (en_log[4] !== 2'b01 || addr_log[4][IW-1:0] !== 8'd6 || en_cycles !== e.en_cycles) begin fails++; $display("FAIL miss7_last_pair: got en=%b addr=%0d cycles=%0d expected 01 6 %0d", en_log[4], addr_log[4][IW-1:0], en_cycles, e.en_cycles); end
    consume();
    do_lookup(32'd100, 0);
    e = sb.pop_front();
    tests++; if (act_lat !== e.lat || act_hit !== 1'b0) begin fails++; $display("FAIL count0: got lat=%0d hit=%b expected lat=%0d hit=0", act_lat, act_hit, e.lat); end
    tests++; if (en_cycles !== 0) begin fails++; $display("FAIL count0_reads: got %0d expected 0", en_cycles); end
    consume();
  endtask

  task automatic test_backpressure();
    exp_t e;
    do_lookup(32'd103, 8);
    e = sb.pop_front();
    tests++; if ({act_hit, act_idx} !== {e.hit, e.idx} || act_lat !== e.lat) begin fails++; $display("FAIL bp_result: got hit=%b idx=%0d lat=%0d expected hit=%b idx=%0d lat=%0d", act_hit, act_idx, act_lat, e.hit, e.idx, e.lat); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++; if ({bus.rsp_valid, bus.rsp_hit, bus.rsp_index, bus.req_ready} !== {1'b1, e.hit, e.idx, 1'b0}) begin fails++; $display("FAIL bp_hold: cycle %0d got v=%b h=%b i=%0d rdy=%b expected v=1 h=%b i=%0d rdy=0", i, bus.rsp_valid, bus.rsp_hit, bus.rsp_index, bus.req_ready, e.hit, e.idx); end
    end
    consume();
    tests++; if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin fails++; $display("FAIL bp_release: got rdy=%b v=%b expected rdy=1 v=0", bus.req_ready, bus.rsp_valid); end
  endtask

  task automatic test_reset_mid_scan();
    exp_t e;
    fill_seq(32'h1000);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_key = 32'hFFFF0000; bus.num_keys = 9'd256;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    tests++; if (bus.r_en !== 2'b11) begin fails++; $display("FAIL rst_scan_active: got en=%b expected 11", bus.r_en); end
    reset = 1'b0;
    #1;
    tests++; if ({bus.r_en, bus.rsp_valid, bus.req_ready} !== 4'b0001) begin fails++; $display("FAIL rst_abandon: got en=%b v=%b rdy=%b expected 00 0 1", bus.r_en, bus.rsp_valid, bus.req_ready); end
    @(negedge clk);
    reset = 1'b1;
    do_lookup(32'h1000 + 200, 256);
    e = sb.pop_front();
    tests++; if ({act_hit, act_idx} !== {1'b1, 8'd200} || act_lat !== e.lat) begin fails++; $display("FAIL rst_recover: got hit=%b idx=%0d lat=%0d expected hit=1 idx=200 lat=%0d", act_hit, act_idx, act_lat, e.lat); end
    consume();
  endtask

  task automatic test_full_table();
    exp_t e;
    do_lookup(32'h1000 + 255, 300);
    e = sb.pop_front();
    tests++; if ({act_hit, act_idx} !== {1'b1, 8'd255} || act_lat !== e.lat) begin fails++; $display("FAIL full_hit: got hit=%b idx=%0d lat=%0d expected hit=1 idx=255 lat=%0d", act_hit, act_idx, act_lat, e.lat); end
    tests++; if (last_en_cyc !== 128 || addr_log[128] !== {8'd255, 8'd254} || en_log[128] !== 2'b11) begin fails++; $display("FAIL full_last_pair: got cyc=%0d addr=%h en=%b expected 128 fffe 11", last_en_cyc, addr_log[128], en_log[128]); end
    consume();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [KW-1:0] keys [3];
    int nums [3];
    keys[0] = 32'h1000 + 17; nums[0] = 256;
    keys[1] = 32'h1000 + 40; nums[1] = 40;
    keys[2] = 32'h1000 + 2;  nums[2] = 3;
    for (int t = 0; t < 3; t++) begin
      do_lookup(keys[t], nums[t]);
      e = sb.pop_front();
      tests++; if ({act_hit, act_idx} !== {e.hit, e.idx} || act_lat !== e.lat || en_cycles !== e.en_cycles) begin fails++; $display("FAIL b2b_%0d: got hit=%b idx=%0d lat=%0d en=%0d expected hit=%b idx=%0d lat=%0d en=%0d", t, act_hit, act_idx, act_lat, en_cycles, e.hit, e.idx, e.lat, e.en_cycles); end
      consume();
    end
    tests++; if (sb.size() !== 0) begin fails++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size()); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_key = '0; bus.num_keys = '0; bus.rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    test_reset();
    test_hit_first();
    test_hit_mid();
    test_duplicate();
    test_miss();
    test_backpressure();
    test_reset_mid_scan();
    test_full_table();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
